// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: decodes one access at a time, steers byte lanes
// to a word-addressed RAM over req/gnt/rvalid, and extends load data.
module load_store_unit #(
  parameter int DATA_WIDTH        = 32,
  parameter int RAM_ADDRESS_WIDTH = 18,
  parameter int TIMEOUT           = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [2:0]                   req_funct3,
  input  logic [DATA_WIDTH-1:0]        req_addr,
  input  logic [DATA_WIDTH-1:0]        req_wdata,
  output logic                         resp_valid,
  output logic [DATA_WIDTH-1:0]        resp_rdata,
  output logic                         resp_err,
  output logic                         stall,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [RAM_ADDRESS_WIDTH-3:0] mem_addr,
  output logic [3:0]                   mem_be,
  output logic [DATA_WIDTH-1:0]        mem_wdata,
  input  logic                         mem_gnt,
  input  logic                         mem_rvalid,
  input  logic [DATA_WIDTH-1:0]        mem_rdata
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                       state_q, state_d;
  logic                         we_q, we_d;
  logic [2:0]                   f3_q, f3_d;
  logic [RAM_ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]        wdata_q, wdata_d;
  logic [3:0]                   be_q, be_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]        rdata_q, rdata_d;
  logic                         err_q, err_d;

  logic                  dec_err;
  logic [3:0]            dec_be;
  logic [DATA_WIDTH-1:0] dec_wdata;
  logic [DATA_WIDTH-1:0] ld_data;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic                  timeout_hit;

  // Request decode: range, funct3 legality, alignment and store lane steering.
  always_comb begin
    dec_err = |req_addr[DATA_WIDTH-1:RAM_ADDRESS_WIDTH];
    if (req_we) begin
      if (req_funct3 > 3'b010) dec_err = 1'b1;
    end else if (req_funct3[1:0] == 2'b11 || req_funct3 == 3'b110) begin
      dec_err = 1'b1;
    end
    if (req_funct3[1:0] == 2'b01 && req_addr[0]) dec_err = 1'b1;
    if (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00) dec_err = 1'b1;
    case (req_funct3[1:0])
      2'b00: begin
        dec_be    = 4'b0001 << req_addr[1:0];
        dec_wdata = {(DATA_WIDTH/8){req_wdata[7:0]}};
      end
      2'b01: begin
        dec_be    = req_addr[1] ? 4'b1100 : 4'b0011;
        dec_wdata = {(DATA_WIDTH/16){req_wdata[15:0]}};
      end
      default: begin
        dec_be    = 4'b1111;
        dec_wdata = req_wdata;
      end
    endcase
  end

  always_comb begin
    ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    ld_half = mem_rdata[{addr_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  ld_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
      3'b001:  ld_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
      3'b101:  ld_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  // Counter value during the last permitted ISSUE/WAIT cycle; completion in
  // that cycle still takes priority over the abort.
  assign timeout_hit = (cnt_q >= CW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (state_q == ISSUE || state_q == WAIT) begin
      if (cnt_q != CW'(TIMEOUT)) cnt_d = cnt_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr[RAM_ADDRESS_WIDTH-1:0];
          wdata_d = dec_wdata;
          be_d    = dec_be;
          cnt_d   = '0;
          rdata_d = '0;
          err_d   = dec_err;
          state_d = dec_err ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        if (mem_gnt) begin
          state_d = we_q ? RESP : WAIT;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          rdata_d = ld_data;
          state_d = RESP;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    stall      = ~req_ready;
    mem_req    = (state_q == ISSUE);
    mem_we     = mem_req & we_q;
    mem_be     = mem_req ? be_q : 4'b0000;
    mem_addr   = addr_q[RAM_ADDRESS_WIDTH-1:2];
    mem_wdata  = wdata_q;
    resp_valid = (state_q == RESP);
    resp_err   = resp_valid & err_q;
    resp_rdata = resp_valid ? rdata_q : '0;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed plan cases, timeout
// boundaries, reset mid-transaction and randomized accesses against a model.
module tb_load_store_unit;

  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err, stall;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [15:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata, mem_rdata;

  int total = 0;
  int bad   = 0;

  // observations from the most recent access
  bit          obs_done, obs_req, obs_stable, obs_ready0, obs_busy_ok, obs_req_at_resp, obs_we;
  int          obs_cycles, obs_issue;
  logic        obs_err;
  logic [31:0] obs_rdata, obs_wd;
  logic [15:0] obs_addr;
  logic [3:0]  obs_be;

  load_store_unit #(
    .DATA_WIDTH(32),
    .RAM_ADDRESS_WIDTH(18),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Reference: RV32I access semantics in plain arithmetic.
  function automatic void model(input logic we, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, output logic err,
                                output logic [31:0] rdata, output logic [3:0] be,
                                output logic [31:0] wdo);
    int     n;
    longint mask, v;
    err = (a >= 32'h40000);
    if (we) err = err | (f3 > 3'd2);
    else    err = err | (f3 == 3'd3) | (f3 == 3'd6) | (f3 == 3'd7);
    rdata = '0; be = '0; wdo = '0;
    if (err) return;
    n = 1 << f3[1:0];
    if ((a % n) != 0) begin err = 1'b1; return; end
    be   = 4'(((1 << n) - 1) << (a % 4));
    mask = (64'd1 << (8 * n)) - 1;
    if (n == 1)      wdo = (wd & 32'hFF) * 32'h01010101;
    else if (n == 2) wdo = (wd & 32'hFFFF) * 32'h00010001;
    else             wdo = wd;
    if (!we) begin
      v = (longint'(rd) >> (8 * (a % 4))) & mask;
      if (f3[2] == 1'b0 && n < 4 && ((v >> (8 * n - 1)) & 1) == 1) v = v | (~mask);
      rdata = 32'(v);
    end
  endfunction

  // Drives one access starting at a negedge in IDLE; gd = ISSUE cycles before
  // gnt, rdl = cycles from gnt to rvalid. Leaves the bench at the next IDLE negedge.
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd,
                            input int gd, input int rdl, input bit hold);
    int g_cyc;
    obs_done = 0; obs_req = 0; obs_stable = 1; obs_busy_ok = 1; obs_req_at_resp = 0;
    obs_issue = 0; obs_cycles = 0; obs_err = 1'bx; obs_rdata = 'x;
    obs_ready0 = req_ready;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    @(negedge clk);
    if (hold) begin
      req_addr = $urandom; req_we = ~we; req_wdata = $urandom;
    end else begin
      req_valid = 1'b0;
    end
    g_cyc = -1;
    for (int c = 1; c <= 2 * TO + 50; c++) begin
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (resp_valid) begin
        obs_cycles = c; obs_err = resp_err; obs_rdata = resp_rdata;
        obs_req_at_resp = mem_req; obs_done = 1;
        req_valid = 1'b0;
        break;
      end
      if (req_ready || !stall) obs_busy_ok = 0;
      if (mem_req) begin
        if (!obs_req) begin
          obs_addr = mem_addr; obs_be = mem_be; obs_wd = mem_wdata; obs_we = mem_we;
        end else if (mem_addr !== obs_addr || mem_be !== obs_be ||
                     mem_wdata !== obs_wd || mem_we !== obs_we) begin
          obs_stable = 0;
        end
        obs_req = 1;
        if (obs_issue == gd) begin mem_gnt = 1'b1; g_cyc = c; end
        obs_issue++;
      end
      if (g_cyc >= 0 && c == g_cyc + rdl) begin mem_rvalid = 1'b1; mem_rdata = rd; end
      @(negedge clk);
    end
    mem_gnt = 1'b0; mem_rvalid = 1'b0; req_valid = 1'b0;
    if (!obs_done) begin
      rst = 1'b1; @(negedge clk); rst = 1'b0;
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    #3;
    total++;
    if ({req_ready, stall, resp_valid, resp_err, mem_req, mem_we} !== 6'b100000) begin
      bad++; $display("FAIL reset_ctrl: got %b want 100000",
                      {req_ready, stall, resp_valid, resp_err, mem_req, mem_we});
    end
    total++;
    if ({resp_rdata, mem_addr, mem_be, mem_wdata} !== '0) begin
      bad++; $display("FAIL reset_data: rdata=%h addr=%h be=%b wdata=%h want all 0",
                      resp_rdata, mem_addr, mem_be, mem_wdata);
    end
    @(negedge clk); rst = 1'b0; @(negedge clk);
  endtask

  task automatic test_store_load();
    // {we, f3, addr, wdata, rdata, gd, rdl, exp_be, exp_wd, exp_rdata}
    logic        we[6]  = '{1, 1, 0, 0, 0, 0};
    logic [2:0]  f3[6]  = '{3'b010, 3'b000, 3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] ad[6]  = '{32'h100, 32'h103, 32'h103, 32'h103, 32'h102, 32'h102};
    logic [31:0] wd[6]  = '{32'hDEADBEEF, 32'h000000A5, 0, 0, 0, 0};
    logic [31:0] rd[6]  = '{0, 0, 32'hA5000000, 32'hA5000000, 32'h80010000, 32'h80010000};
    int          rl[6]  = '{1, 1, 3, 3, 1, 1};
    logic [3:0]  ebe[6] = '{4'b1111, 4'b1000, 0, 0, 0, 0};
    logic [31:0] ewd[6] = '{32'hDEADBEEF, 32'hA5A5A5A5, 0, 0, 0, 0};
    logic [31:0] erd[6] = '{0, 0, 32'hFFFFFFA5, 32'h000000A5, 32'hFFFF8001, 32'h00008001};
    for (int i = 0; i < 6; i++) begin
      run_access(we[i], f3[i], ad[i], wd[i], rd[i], 0, rl[i], 0);
      total++;
      if (obs_err !== 1'b0 || obs_rdata !== erd[i]) begin
        bad++; $display("FAIL dir_resp[%0d]: err=%b rdata=%h want err=0 rdata=%h",
                        i, obs_err, obs_rdata, erd[i]);
      end
      total++;
      if (obs_cycles != (we[i] ? 2 : 2 + rl[i])) begin
        bad++; $display("FAIL dir_latency[%0d]: got %0d want %0d",
                        i, obs_cycles, we[i] ? 2 : 2 + rl[i]);
      end
      total++;
      if (obs_addr !== ad[i][17:2] || obs_we !== we[i]) begin
        bad++; $display("FAIL dir_addr[%0d]: addr=%h we=%b want %h %b",
                        i, obs_addr, obs_we, ad[i][17:2], we[i]);
      end
      if (we[i]) begin
        total++;
        if (obs_be !== ebe[i] || obs_wd !== ewd[i]) begin
          bad++; $display("FAIL dir_lanes[%0d]: be=%b wdata=%h want %b %h",
                          i, obs_be, obs_wd, ebe[i], ewd[i]);
        end
      end
    end
  endtask

  task automatic test_errors();
    logic        we[5] = '{0, 1, 0, 0, 1};
    logic [2:0]  f3[5] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100};
    logic [31:0] ad[5] = '{32'h101, 32'h001, 32'h40000, 32'h100, 32'h100};
    for (int i = 0; i < 5; i++) begin
      run_access(we[i], f3[i], ad[i], 32'h12345678, 32'h0, 0, 1, 0);
      total++;
      if (obs_err !== 1'b1 || obs_rdata !== 32'h0 || obs_cycles != 1 || obs_req) begin
        bad++; $display("FAIL err_case[%0d]: err=%b rdata=%h cyc=%0d req=%0d want 1 0 1 0",
                        i, obs_err, obs_rdata, obs_cycles, obs_req);
      end
    end
  endtask

  task automatic test_timeout();
    run_access(0, 3'b010, 32'h200, 0, 32'h11, 100000, 1, 0);
    total++;
    if (obs_err !== 1'b1 || obs_cycles != TO + 1 || obs_issue != TO || obs_req_at_resp) begin
      bad++; $display("FAIL timeout_nogt: err=%b cyc=%0d issue=%0d req@resp=%0d want 1 %0d %0d 0",
                      obs_err, obs_cycles, obs_issue, obs_req_at_resp, TO + 1, TO);
    end
    run_access(1, 3'b010, 32'h204, 32'h55, 0, TO - 1, 1, 0);
    total++;
    if (obs_err !== 1'b0 || obs_cycles != TO + 1) begin
      bad++; $display("FAIL timeout_gnt_last: err=%b cyc=%0d want 0 %0d", obs_err, obs_cycles, TO + 1);
    end
    run_access(1, 3'b010, 32'h208, 32'h66, 0, TO, 1, 0);
    total++;
    if (obs_err !== 1'b1 || obs_cycles != TO + 1) begin
      bad++; $display("FAIL timeout_gnt_late: err=%b cyc=%0d want 1 %0d", obs_err, obs_cycles, TO + 1);
    end
  endtask

  task automatic test_reset_mid();
    req_valid = 1; req_we = 0; req_funct3 = 3'b010; req_addr = 32'h300; req_wdata = 0;
    @(posedge clk); @(negedge clk);
    req_valid = 0; mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    #2 rst = 1'b1;
    #1;
    total++;
    if ({req_ready, stall, resp_valid, resp_err, mem_req, mem_we} !== 6'b100000 ||
        {resp_rdata, mem_addr, mem_be, mem_wdata} !== '0) begin
      bad++; $display("FAIL reset_mid: ctrl=%b addr=%h be=%b wdata=%h want 100000/0",
                      {req_ready, stall, resp_valid, resp_err, mem_req, mem_we},
                      mem_addr, mem_be, mem_wdata);
    end
    @(negedge clk); rst = 1'b0;
    mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
        bad++; $display("FAIL stray_rvalid[%0d]: resp_valid=%b ready=%b want 0 1", i, resp_valid, req_ready);
      end
    end
    mem_rvalid = 0;
    run_access(0, 3'b010, 32'h304, 0, 32'hCAFEF00D, 1, 2, 0);
    total++;
    if (obs_err !== 1'b0 || obs_rdata !== 32'hCAFEF00D || obs_cycles != 5) begin
      bad++; $display("FAIL post_reset_lw: err=%b rdata=%h cyc=%0d want 0 cafef00d 5",
                      obs_err, obs_rdata, obs_cycles);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    for (int i = 0; i < 4; i++) begin
      rd = $urandom;
      run_access(i[0], 3'b010, 32'h400 + 4 * i, rd, rd, 0, 1, i == 2);
      total++;
      if (obs_ready0 !== 1'b1 || obs_err !== 1'b0 || obs_rdata !== (i[0] ? 32'h0 : rd) ||
          !obs_stable || !obs_busy_ok) begin
        bad++; $display("FAIL b2b[%0d]: ready0=%b err=%b rdata=%h stable=%0d busy=%0d want 1 0 %h 1 1",
                        i, obs_ready0, obs_err, obs_rdata, obs_stable, obs_busy_ok,
                        i[0] ? 32'h0 : rd);
      end
    end
  endtask

  task automatic test_random();
    logic        we, e_err;
    logic [2:0]  f3;
    logic [31:0] a, wd, rd, e_rd, e_wd;
    logic [3:0]  e_be;
    int          gd, rdl, e_cyc;
    for (int i = 0; i < 80; i++) begin
      we = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom_range(0, 32'h3FFFF);
      if ($urandom_range(0, 9) == 0) a = a | (32'h1 << $urandom_range(18, 31));
      wd = $urandom; rd = $urandom;
      gd = $urandom_range(0, 3); rdl = $urandom_range(1, 3);
      model(we, f3, a, wd, rd, e_err, e_rd, e_be, e_wd);
      e_cyc = e_err ? 1 : (we ? gd + 2 : gd + rdl + 2);
      run_access(we, f3, a, wd, rd, gd, rdl, 0);
      total++;
      if (obs_err !== e_err || obs_rdata !== e_rd || obs_cycles != e_cyc || obs_req != !e_err) begin
        bad++; $display("FAIL rnd_resp[%0d] we=%b f3=%b a=%h: err=%b rd=%h cyc=%0d req=%0d want %b %h %0d %0d",
                        i, we, f3, a, obs_err, obs_rdata, obs_cycles, obs_req,
                        e_err, e_rd, e_cyc, !e_err);
      end
      if (!e_err) begin
        total++;
        if (obs_addr !== a[17:2] || obs_we !== we || !obs_stable ||
            (we && (obs_be !== e_be || obs_wd !== e_wd))) begin
          bad++; $display("FAIL rnd_mem[%0d]: addr=%h we=%b be=%b wd=%h st=%0d want %h %b %b %h 1",
                          i, obs_addr, obs_we, obs_be, obs_wd, obs_stable, a[17:2], we, e_be, e_wd);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_errors();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the execute stage (ALU result as effective address) and the data memory. Accepts one access at a time: alignment, range and funct3 checks, byte-lane steering, and load sign/zero extension. Talks to a word-addressed RAM over a request/grant/read-valid handshake. Holds the pipeline through `stall` while a transaction is in flight.

## Interface
- DATA_WIDTH, 32, data/address width on the CPU side
- RAM_ADDRESS_WIDTH, 18, byte-address width of data memory; the word address is RAM_ADDRESS_WIDTH-2 bits
- TIMEOUT, 255, max cycles spent in ISSUE+WAIT before aborting with error; counter is $clog2(TIMEOUT+1) bits
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  access request from execute stage
- req_ready  out  1  unit can accept; high iff state==IDLE
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW
- req_addr  in  DATA_WIDTH  byte effective address
- req_wdata  in  DATA_WIDTH  store data (rs2)
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
- resp_err  out  1  valid with resp_valid: misaligned, out of range, illegal funct3, or timeout
- stall  out  1  = !req_ready
- mem_req  out  1  memory request, held until mem_gnt
- mem_we  out  1  write enable
- mem_addr  out  RAM_ADDRESS_WIDTH-2  word address = addr[RAM_ADDRESS_WIDTH-1:2]
- mem_be  out  4  byte enables
- mem_wdata  out  DATA_WIDTH  lane-replicated store data
- mem_gnt  in  1  memory accepted request
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_WIDTH  read word

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, register we, funct3, addr, wdata and decode, then:
  - error → RESP with err=1, no memory access;
  - otherwise → ISSUE with the timeout counter cleared.
- Error conditions:
  - addr[31:RAM_ADDRESS_WIDTH] != 0 (out of range);
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - load funct3 in {011,110,111};
  - store funct3 > 010.
- ISSUE: mem_req=1 with mem_we, mem_addr, mem_be, mem_wdata stable. On mem_gnt: store → RESP; load → WAIT.
- WAIT: on mem_rvalid, capture the extracted result → RESP.
- RESP: resp_valid=1 for exactly one cycle → IDLE. The response has no backpressure.
- Store steering:
  - SB: wdata={4{b}}, be=4'b0001<<addr[1:0];
  - SH: wdata={2{h}}, be=addr[1]?4'b1100:4'b0011;
  - SW: be=4'b1111.
- Load extraction:
  - LB/LBU: byte = rdata[8*addr[1:0]+:8];
  - LH/LHU: half = rdata[16*addr[1]+:16];
  - sign-extend for LB/LH, zero-extend for LBU/LHU, LW passes the word through.
- Timeout: counter increments each cycle in ISSUE or WAIT. When it reaches TIMEOUT without completion → RESP with err=1, mem_req dropped.
- Outside ISSUE: mem_req=0, mem_we=0, mem_be=0. mem_addr/mem_wdata hold their registered values.

## Timing
- Reset (async, immediate): state=IDLE, so req_ready=1 and stall=0. resp_valid=0, resp_err=0, resp_rdata=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, counter=0.
- Reset mid-transaction abandons it. A later mem_gnt/mem_rvalid arriving in IDLE is ignored.
- Store, gnt in first ISSUE cycle: accept at edge 0, ISSUE in cycle 1, resp_valid in cycle 2.
- Load, gnt in cycle 1 and rvalid in cycle 2: resp_valid in cycle 3.
- Error: accept at edge 0, resp_valid with err in cycle 1.
- mem_rvalid counts only in WAIT, never in the ISSUE cycle that carries mem_gnt.
- req_valid while not IDLE is ignored. The requester must hold the request until it sees req_ready.
- If mem_gnt/mem_rvalid coincides with the cycle the counter reaches TIMEOUT, completion wins (err=0).
- Back-to-back: a new request is accepted in the IDLE cycle immediately following RESP.

## Test plan
- SW addr 0x100, data 0xDEADBEEF, immediate gnt → mem_addr=0x40, be=1111, wdata=0xDEADBEEF; resp_valid in cycle 2 with err=0, rdata=0.
- SB addr 0x103, data 0x000000A5 → be=1000, wdata=0xA5A5A5A5. Then LB addr 0x103 with rdata 0xA5000000, rvalid 3 cycles after gnt → rdata=0xFFFFFFA5. LBU → 0x000000A5.
- LH addr 0x102, rdata 0x80010000 → 0xFFFF8001. LHU → 0x00008001.
- Errors, each giving resp_valid next cycle with err=1 and mem_req never asserted:
  - LW addr 0x101;
  - SH addr 0x001;
  - LW addr 0x40000;
  - load funct3 011.
- Timeout: LW with mem_gnt held low → err=1 after TIMEOUT cycles, mem_req deasserts. A separate run with gnt arriving on the TIMEOUT cycle → err=0.
- Reset asserted in WAIT → all outputs at reset values immediately. A stray mem_rvalid after release yields no resp_valid, and the next LW completes normally.
